// File: rtl/stft_frame_sched.sv
// Windowing-stage sequencer for the STFT/mel front end: loads the window LUT, then paces samples frame by frame.
// Optional stall statistics output enabled by defining STFT_SCHED_STATS_EN.
module stft_frame_sched #(
  parameter int WIDTH  = 16,
  parameter int NFFT_W = 10,
  parameter int WIN_W  = 10,
  parameter int HOP_W  = 9,
  parameter int FRM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [NFFT_W-1:0] cfg_n_fft,
  input  logic [WIN_W-1:0]  cfg_win_len,
  input  logic [HOP_W-1:0]  cfg_hop_len,
  input  logic [FRM_W-1:0]  cfg_frames,
  input  logic              abort,
  input  logic              coe_valid,
  input  logic [WIDTH-1:0]  coe_data,
  output logic              coe_ready,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              fft_ready,
  output logic              win_lut_en,
  output logic [WIDTH-1:0]  win_coe,
  output logic              win_den,
  output logic              frame_sof,
  output logic              frame_eof,
  output logic [FRM_W-1:0]  frame_idx,
  output logic              busy,
  output logic              done,
`ifdef STFT_SCHED_STATS_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              cfg_err
);

  localparam int CMP_A = (NFFT_W > WIN_W) ? NFFT_W : WIN_W;
  localparam int CMP_W = (CMP_A > HOP_W) ? CMP_A : HOP_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [NFFT_W-1:0]  n_fft_q;
  logic [WIN_W-1:0]   win_len_q;
  logic [HOP_W-1:0]   hop_len_q;
  logic [FRM_W-1:0]   frames_q;
  logic [WIN_W-1:0]   coe_cnt_q;
  logic [NFFT_W-1:0]  slot_q;
  logic [FRM_W-1:0]   frame_idx_q;
  logic               win_lut_en_q;
  logic [WIDTH-1:0]   win_coe_q;
  logic               win_den_q;
  logic               sof_q;
  logic               eof_q;
  logic               done_q;
  logic               cfg_err_q;
`ifdef STFT_SCHED_STATS_EN
  logic [31:0]        stall_cnt_q;
`endif

  // Widened views so every length comparison happens at a common width.
  logic [CMP_W-1:0] slot_x, nfft_x, win_x, hop_x, cnt_x;
  logic [CMP_W-1:0] cfg_nfft_x, cfg_win_x, cfg_hop_x;
  logic             need_s, fire_s, coe_acc_s, last_slot_s, last_coe_s, cfg_bad_s;

  assign slot_x     = CMP_W'(slot_q);
  assign nfft_x     = CMP_W'(n_fft_q);
  assign win_x      = CMP_W'(win_len_q);
  assign hop_x      = CMP_W'(hop_len_q);
  assign cnt_x      = CMP_W'(coe_cnt_q);
  assign cfg_nfft_x = CMP_W'(cfg_n_fft);
  assign cfg_win_x  = CMP_W'(cfg_win_len);
  assign cfg_hop_x  = CMP_W'(cfg_hop_len);

  // Handshake qualification; abort suppresses any transfer in its cycle.
  always_comb begin
    need_s      = 1'b0;
    fire_s      = 1'b0;
    s_ready     = 1'b0;
    coe_ready   = 1'b0;
    coe_acc_s   = 1'b0;
    last_slot_s = (slot_x == (nfft_x - CMP_W'(1'b1)));
    last_coe_s  = (cnt_x == (win_x - CMP_W'(1'b1)));
    cfg_bad_s   = (cfg_nfft_x == '0) || (cfg_win_x == '0) || (cfg_win_x > cfg_nfft_x) ||
                  (cfg_hop_x == '0) || (cfg_hop_x > cfg_win_x) || (cfg_frames == '0);
    if (state_q == S_RUN && !abort) begin
      need_s  = (frame_idx_q == '0) ? (slot_x < win_x) : (slot_x < hop_x);
      s_ready = need_s & fft_ready;
      fire_s  = fft_ready & (!need_s | s_valid);
    end else if (state_q == S_LOAD && !abort) begin
      coe_ready = 1'b1;
      coe_acc_s = coe_valid;
    end else begin
      need_s = 1'b0;
    end
  end

  // Sequencer state, counters and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      n_fft_q      <= '0;
      win_len_q    <= '0;
      hop_len_q    <= '0;
      frames_q     <= '0;
      coe_cnt_q    <= '0;
      slot_q       <= '0;
      frame_idx_q  <= '0;
      win_lut_en_q <= 1'b0;
      win_coe_q    <= '0;
      win_den_q    <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
`ifdef STFT_SCHED_STATS_EN
      stall_cnt_q  <= 32'd0;
`endif
    end else begin
      win_lut_en_q <= 1'b0;
      win_den_q    <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cfg_start) begin
              n_fft_q   <= cfg_n_fft;
              win_len_q <= cfg_win_len;
              hop_len_q <= cfg_hop_len;
              frames_q  <= cfg_frames;
              if (cfg_bad_s) begin
                cfg_err_q <= 1'b1;
              end else begin
                state_q     <= S_LOAD;
                coe_cnt_q   <= '0;
                slot_q      <= '0;
                frame_idx_q <= '0;
`ifdef STFT_SCHED_STATS_EN
                stall_cnt_q <= 32'd0;
`endif
              end
            end
          end
          S_LOAD: begin
            if (coe_acc_s) begin
              win_lut_en_q <= 1'b1;
              win_coe_q    <= coe_data;
              coe_cnt_q    <= coe_cnt_q + WIN_W'(1'b1);
              if (last_coe_s) begin
                state_q     <= S_RUN;
                slot_q      <= '0;
                frame_idx_q <= '0;
              end
            end
          end
          S_RUN: begin
            if (fire_s) begin
              win_den_q <= 1'b1;
              sof_q     <= (slot_q == '0);
              eof_q     <= last_slot_s;
              if (last_slot_s) begin
                slot_q      <= '0;
                frame_idx_q <= frame_idx_q + FRM_W'(1'b1);
                if (frame_idx_q == (frames_q - FRM_W'(1'b1))) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end
              end else begin
                slot_q <= slot_q + NFFT_W'(1'b1);
              end
            end else begin
`ifdef STFT_SCHED_STATS_EN
              if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
`endif
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign win_lut_en = win_lut_en_q;
  assign win_coe    = win_coe_q;
  assign win_den    = win_den_q;
  assign frame_sof  = sof_q;
  assign frame_eof  = eof_q;
  assign frame_idx  = frame_idx_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;
`ifdef STFT_SCHED_STATS_EN
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule
